// File: rtl/command_frame_decoder.sv
// Command frame decoder: pops 40-bit frames from an RX FIFO, performs the register
// read or write they carry, and pushes a 40-bit response frame into a TX FIFO.
module command_frame_decoder #(
  parameter int unsigned Read_Timeout = 255,
  parameter bit          Write_Echo   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RX_Fifo_Empty,
  input  logic [39:0] RX_Fifo_Data,
  output logic        RX_Fifo_RE,
  input  logic        TX_Fifo_Full,
  output logic        TX_Fifo_WE,
  output logic [39:0] TX_Fifo_Data,
  output logic [6:0]  Reg_Addr,
  output logic [31:0] Reg_WData,
  output logic        Reg_WE,
  output logic        Reg_RE,
  input  logic [31:0] Reg_RData,
  input  logic        Reg_RValid,
  output logic        Busy,
  output logic [7:0]  Error_Count
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, RWAIT, RESP} state_t;

  localparam logic [15:0] TimeoutLast = 16'(Read_Timeout - 1);

  state_t      state_q, state_d;
  logic [39:0] frame_q, frame_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  err_q, err_d;
  logic        rx_re_q, rx_re_d;
  logic        tx_we_q, tx_we_d;
  logic [39:0] tx_data_q, tx_data_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        reg_re_q, reg_re_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    timer_d     = timer_q;
    err_d       = err_q;
    rx_re_d     = 1'b0;
    tx_we_d     = 1'b0;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!RX_Fifo_Empty) begin
          state_d = FETCH;
          rx_re_d = 1'b1;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // Strobes are registered, so they are decoded from the FIFO word here to be high during EXEC.
        frame_d    = RX_Fifo_Data;
        reg_addr_d = RX_Fifo_Data[38:32];
        if (RX_Fifo_Data[39]) begin
          reg_re_d = 1'b1;
        end else begin
          reg_we_d    = 1'b1;
          reg_wdata_d = RX_Fifo_Data[31:0];
        end
        state_d = EXEC;
      end
      EXEC: begin
        if (frame_q[39]) begin
          timer_d = '0;
          state_d = RWAIT;
        end else if (Write_Echo) begin
          tx_data_d = frame_q;
          state_d   = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RWAIT: begin
        // Valid data takes priority over a timeout landing in the same cycle.
        if (Reg_RValid) begin
          tx_data_d = {frame_q[39:32], Reg_RData};
          state_d   = RESP;
        end else if (timer_q == TimeoutLast) begin
          tx_data_d = {8'hFF, 24'h000000, frame_q[39:32]};
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        if (!TX_Fifo_Full) begin
          tx_we_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The frame stays busy through the cycle its response strobe is on the TX FIFO.
    busy_d = (state_d != IDLE) || tx_we_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      timer_q     <= '0;
      err_q       <= '0;
      rx_re_q     <= 1'b0;
      tx_we_q     <= 1'b0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      rx_re_q     <= rx_re_d;
      tx_we_q     <= tx_we_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  assign RX_Fifo_RE   = rx_re_q;
  assign TX_Fifo_WE   = tx_we_q;
  assign TX_Fifo_Data = tx_data_q;
  assign Reg_Addr     = reg_addr_q;
  assign Reg_WData    = reg_wdata_q;
  assign Reg_WE       = reg_we_q;
  assign Reg_RE       = reg_re_q;
  assign Busy         = busy_q;
  assign Error_Count  = err_q;

endmodule

// File: doc/command_frame_decoder.md
COMMAND_FRAME_DECODER -- requirements
Module: command_frame_decoder

Interface
REQ-001 SHALL have parameter Read_Timeout, default 255: cycles to wait for Reg_RValid after Reg_RE (range 1..65535).
REQ-002 SHALL have parameter Write_Echo, default 1: 1 = each write returns a response frame; 0 = writes return nothing.
REQ-003 Clock  in  1  single clock domain; all logic rising-edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 RX_Fifo_Empty  in  1  command FIFO empty.
REQ-006 RX_Fifo_Data  in  40  command frame; Q valid 1 cycle after RE.
REQ-007 RX_Fifo_RE  out  1  command FIFO read strobe.
REQ-008 TX_Fifo_Full  in  1  response FIFO full.
REQ-009 TX_Fifo_WE  out  1  response FIFO write strobe.
REQ-010 TX_Fifo_Data  out  40  response frame.
REQ-011 Reg_Addr  out  7  register address.
REQ-012 Reg_WData  out  32  register write data.
REQ-013 Reg_WE  out  1  register write strobe.
REQ-014 Reg_RE  out  1  register read strobe.
REQ-015 Reg_RData  in  32  register read data, qualified by Reg_RValid.
REQ-016 Reg_RValid  in  1  read data valid.
REQ-017 Busy  out  1  high whenever state /= IDLE.
REQ-018 Error_Count  out  8  saturating read-timeout counter.

Function
REQ-019 Frame format SHALL be: bit 39 = R/nW, bits 38:32 = address, bits 31:0 = data.
REQ-020 FSM states SHALL be IDLE, FETCH, LATCH, EXEC, RWAIT, RESP. All strobes SHALL be registered and one cycle wide.
REQ-021 IDLE: when RX_Fifo_Empty=0, go to FETCH. Otherwise stay in IDLE.
REQ-022 FETCH: RX_Fifo_RE=1 for exactly this cycle, then go to LATCH.
REQ-023 LATCH: capture RX_Fifo_Data into the frame register, then go to EXEC. The frame register SHALL NOT change again until the next LATCH.
REQ-024 EXEC, bit39=0 (write):
- Reg_WE=1 for one cycle, with Reg_Addr=frame[38:32] and Reg_WData=frame[31:0].
- Response = captured frame unchanged.
- Go to RESP if Write_Echo=1, else go to IDLE.
REQ-025 EXEC, bit39=1 (read): Reg_RE=1 for one cycle with Reg_Addr=frame[38:32]. Clear the timeout counter. Go to RWAIT.
REQ-026 RWAIT: Reg_RValid SHALL be sampled from the cycle after Reg_RE onward.
- On the first cycle with Reg_RValid=1: response = {frame[39:32], Reg_RData}; go to RESP.
- Reg_RValid pulses outside RWAIT SHALL be ignored.
REQ-027 RWAIT timeout:
- If Reg_RValid has not been seen after Read_Timeout cycles: response = {8'hFF, 24'h000000, frame[39:32]}.
- Error_Count increments by 1 and saturates at 255.
- Go to RESP.
- If Reg_RValid and timeout occur in the same cycle, the valid data SHALL win.
REQ-028 RESP:
- While TX_Fifo_Full=1, hold with TX_Fifo_WE=0 and TX_Fifo_Data stable.
- In the first cycle with TX_Fifo_Full=0, TX_Fifo_WE=1 for one cycle; go to IDLE.
REQ-029 TX_Fifo_Data SHALL hold its value from entry to RESP until the next response is loaded.
REQ-030 Exactly one RX_Fifo_RE per frame. No new FETCH SHALL start before the current frame completes (no pipelining).
REQ-031 Minimum command-to-command spacing:
- 4 cycles for a write with Write_Echo=0.
- 5 cycles for a write with Write_Echo=1, with no backpressure.
REQ-032 Reg_Addr and Reg_WData SHALL hold their last values between strobes.

Reset
REQ-033 On Reset=1 at a rising edge:
- state = IDLE.
- All strobes, Busy, Error_Count, Reg_Addr, Reg_WData, TX_Fifo_Data and the frame register = 0.
- The timeout counter = 0.
REQ-034 A reset in any state SHALL abort the frame in flight with no response written. A frame already popped from the FIFO SHALL be lost.

Verification
REQ-035 Write 0x05_DEADBEEF, Write_Echo=1 -> Reg_WE with Addr=0x05, WData=0xDEADBEEF; then TX_Fifo_WE with TX_Fifo_Data=0x05DEADBEEF; Busy for 5 cycles.
REQ-036 Read 0x8A_00000000, Reg_RValid 3 cycles after Reg_RE with RData=0x12345678 -> TX_Fifo_Data=0x8A12345678; Error_Count unchanged.
REQ-037 Read 0x91_xxxxxxxx, no Reg_RValid, Read_Timeout=4 -> TX_Fifo_Data=0xFF00000091; Error_Count 0->1; repeated 260 times -> Error_Count stays 255.
REQ-038 Read response with TX_Fifo_Full=1 for 10 cycles -> TX_Fifo_WE=0 throughout; TX_Fifo_Data stable; single WE in the cycle after Full falls.
REQ-039 Three back-to-back frames queued (RX_Fifo_Empty=0) -> exactly three RX_Fifo_RE pulses, each after the previous frame completes; responses in order.
REQ-040 Reset asserted in RWAIT, then Reg_RValid pulses -> no TX_Fifo_WE; all outputs 0; next frame processes normally.
